// File: rtl/stuff_sched_pkg.sv
// rtl/stuff_sched_pkg.sv - state encoding and channel-index sizing for stuff_frame_scheduler
package stuff_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  // Width of a channel index; never below 1 so a 2-channel build still has a bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among channel requests
// Ports:
//   req_i   [N_CH-1:0]  level request per channel
//   ptr_i   [CH_W-1:0]  highest-priority channel for this pick
//   gnt_o   [N_CH-1:0]  one-hot winner (0 when nothing requests)
//   idx_o   [CH_W-1:0]  index of the winner
//   valid_o             some channel is requesting
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            valid_o
);

  int              c;
  logic [CH_W-1:0] idx;

  // Scan from the farthest offset down to ptr itself so the last hit written
  // is the first requester at or after ptr.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    idx     = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      c = int'(ptr_i) + off;
      if (c >= N_CH) c = c - N_CH;
      idx = CH_W'(c);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        idx_o      = idx;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stuff_frame_scheduler.sv
// rtl/stuff_frame_scheduler.sv - round-robin frame scheduler feeding one shared stuff_or_data datapath
// Optional feature macro: STUFF_SCHED_TIMEOUT_EN (stall timeout abort in RUN).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req        [N_CH]     per-channel level request, sampled in IDLE only
//   ch_pm/ch_cm           per-channel pm/cm, channel i at [i*MPT_W +: MPT_W]
//   ready_in              downstream can take one slot this cycle
//   gnt, gnt_ch           one-hot grant and its index, held SOF..last slot
//   pm_out, cm_out        latched config to datapath pm/cm
//   sof_out, valid_out    datapath sof / valid_in
//   busy                  frame in SOF or RUN
//   frame_done, cfg_err   one-cycle status pulses
//   frame_abort           one-cycle timeout pulse (0 without the macro)
module stuff_frame_scheduler
  import stuff_sched_pkg::*;
#(
  parameter int  MPT_W  = 8,
  parameter int  N_CH   = 4,
  parameter int  TO_CYC = 64,
  localparam int CH_W   = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*MPT_W-1:0] ch_pm,
  input  logic [N_CH*MPT_W-1:0] ch_cm,
  input  logic                  ready_in,
  output logic [N_CH-1:0]       gnt,
  output logic [CH_W-1:0]       gnt_ch,
  output logic [MPT_W-1:0]      pm_out,
  output logic [MPT_W-1:0]      cm_out,
  output logic                  sof_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic                  frame_abort
);

  sched_state_e     state_q;
  logic [CH_W-1:0]  rr_ptr_q;
  logic [CH_W-1:0]  gnt_ch_q;
  logic [N_CH-1:0]  gnt_q;
  logic [MPT_W-1:0] pm_q;
  logic [MPT_W-1:0] cm_q;
  logic [MPT_W-1:0] slot_cnt_q;
  logic [MPT_W-1:0] slot_cnt_d;
  logic             frame_done_q;
  logic             cfg_err_q;

  logic [N_CH-1:0]  arb_gnt;
  logic [CH_W-1:0]  arb_idx;
  logic             arb_any;
  logic [MPT_W-1:0] arb_pm;
  logic [MPT_W-1:0] arb_cm;
  logic             arb_bad;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (int'(c) >= N_CH - 1) ? '0 : c + 1'b1;
  endfunction

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  always_comb begin
    arb_pm = '0;
    arb_cm = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_idx == CH_W'(i)) begin
        arb_pm = ch_pm[i*MPT_W +: MPT_W];
        arb_cm = ch_cm[i*MPT_W +: MPT_W];
      end
    end
  end

  // pm==0 would make slot_cnt wrap; cm>pm cannot be carried by the datapath.
  assign arb_bad    = (arb_pm == '0) || (arb_cm > arb_pm);
  assign slot_cnt_d = slot_cnt_q - 1'b1;

`ifdef STUFF_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] stall_q;
  logic            frame_abort_q;
  logic            stall_hit;
  // Hit on the TO_CYC-th consecutive stalled RUN cycle.
  assign stall_hit   = (stall_q == TO_W'(TO_CYC - 1));
  assign frame_abort = frame_abort_q;
`else
  assign frame_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_ch_q     <= '0;
      gnt_q        <= '0;
      pm_q         <= '0;
      cm_q         <= '0;
      slot_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef STUFF_SCHED_TIMEOUT_EN
      stall_q       <= '0;
      frame_abort_q <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef STUFF_SCHED_TIMEOUT_EN
      frame_abort_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            pm_q     <= arb_pm;
            cm_q     <= arb_cm;
            gnt_ch_q <= arb_idx;
            if (arb_bad) begin
              cfg_err_q <= 1'b1;
              gnt_q     <= '0;
              rr_ptr_q  <= next_ch(arb_idx);
            end else begin
              gnt_q      <= arb_gnt;
              slot_cnt_q <= arb_pm;
              state_q    <= SOF;
`ifdef STUFF_SCHED_TIMEOUT_EN
              stall_q    <= '0;
`endif
            end
          end
        end
        SOF: state_q <= RUN;
        RUN: begin
          if (ready_in) begin
            slot_cnt_q <= slot_cnt_d;
`ifdef STUFF_SCHED_TIMEOUT_EN
            stall_q    <= '0;
`endif
            if (slot_cnt_q == MPT_W'(1)) begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
              gnt_q        <= '0;
              rr_ptr_q     <= next_ch(gnt_ch_q);
            end
          end
`ifdef STUFF_SCHED_TIMEOUT_EN
          else if (stall_hit) begin
            state_q       <= IDLE;
            frame_abort_q <= 1'b1;
            gnt_q         <= '0;
            stall_q       <= '0;
            rr_ptr_q      <= next_ch(gnt_ch_q);
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign gnt_ch     = gnt_ch_q;
  assign pm_out     = pm_q;
  assign cm_out     = cm_q;
  assign sof_out    = (state_q == SOF);
  assign valid_out  = (state_q == RUN) && ready_in;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_stuff_frame_scheduler.sv
// tb/tb_stuff_frame_scheduler.sv - self-checking bench for stuff_frame_scheduler
module tb_stuff_frame_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] ch_pm;
  logic [31:0] ch_cm;
  logic        ready_in;
  logic [3:0]  gnt;
  logic [1:0]  gnt_ch;
  logic [7:0]  pm_out;
  logic [7:0]  cm_out;
  logic        sof_out;
  logic        valid_out;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;
  logic        frame_abort;

  stuff_frame_scheduler #(
    .MPT_W  (8),
    .N_CH   (4),
    .TO_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ch_pm       (ch_pm),
    .ch_cm       (ch_cm),
    .ready_in    (ready_in),
    .gnt         (gnt),
    .gnt_ch      (gnt_ch),
    .pm_out      (pm_out),
    .cm_out      (cm_out),
    .sof_out     (sof_out),
    .valid_out   (valid_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic int outs();
    return int'({gnt, gnt_ch, pm_out, cm_out, sof_out, valid_out,
                 busy, frame_done, cfg_err, frame_abort});
  endfunction

  typedef struct {
    int ch;
    int pm;
    int cm;
    bit err;
  } exp_t;

  typedef struct {
    int ch;
    int pm;
    int cm;
    int mode;     // 0: ready high, 1: ready 1010.., 2: random
    bit err;
    int done_at;  // expected frame_done cycle, 0 = not timed
  } vec_t;

  exp_t sb_q[$];

  // Scoreboard monitor: pops one expected frame per sof_out or cfg_err.
  exp_t cur;
  bit   in_frame;
  int   mon_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (cfg_err) begin
        check("sb_nonempty_err", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          check("err_expected", int'(cur.err), 1);
          check("err_gnt_ch", int'(gnt_ch), cur.ch);
          check("err_gnt_clear", int'(gnt), 0);
        end
      end
      if (sof_out) begin
        check("sof_in_frame", int'(in_frame), 0);
        check("sof_no_valid", int'(valid_out), 0);
        check("sb_nonempty_sof", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          check("sof_not_err", int'(cur.err), 0);
          check("sof_gnt_ch", int'(gnt_ch), cur.ch);
          check("sof_gnt", int'(gnt), 1 << cur.ch);
          check("sof_pm_out", int'(pm_out), cur.pm);
          check("sof_cm_out", int'(cm_out), cur.cm);
        end
        in_frame = 1'b1;
        mon_n    = 0;
      end
      if (valid_out) mon_n++;
      if (frame_done) begin
        check("done_in_frame", int'(in_frame), 1);
        check("done_strobes", mon_n, cur.pm);
        in_frame = 1'b0;
      end
      if (frame_abort) in_frame = 1'b0;
    end
  end

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check(name, outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input int ch, input int pm, input int cm, input bit err);
    exp_t e;
    e.ch = ch; e.pm = pm; e.cm = cm; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input int ch, input int pm, input int cm);
    ch_pm[ch*8 +: 8] = 8'(pm);
    ch_cm[ch*8 +: 8] = 8'(cm);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, sof_at, err_at, fin_at, n;
    bit gnt_bad;
    cyc = 0; sof_at = -1; err_at = -1; fin_at = -1; n = 0; gnt_bad = 1'b0;
    @(posedge clk);
    #1;
    set_cfg(v.ch, v.pm, v.cm);
    push_exp(v.ch, v.pm, v.cm, v.err);
    req[v.ch] = 1'b1;
    while (fin_at < 0 && err_at < 0 && cyc < 700) begin
      @(posedge clk);
      #1;
      cyc++;
      case (v.mode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cyc % 2 == 0);
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (sof_out && sof_at < 0) begin sof_at = cyc; req[v.ch] = 1'b0; end
      if (cfg_err) begin err_at = cyc; req[v.ch] = 1'b0; end
      if (valid_out) n++;
      if (sof_at >= 0 && !frame_done && gnt != 4'(1 << v.ch)) gnt_bad = 1'b1;
      if (frame_done) begin
        fin_at = cyc;
        check("done_gnt_clear", int'(gnt), 0);
        check("done_busy_clear", int'(busy), 0);
        check("done_pm_stable", int'(pm_out), v.pm);
      end
    end
    req = '0;
    ready_in = 1'b0;
    if (v.err) begin
      check("err_cycle", err_at, 1);
      check("err_no_sof", sof_at, -1);
    end else begin
      check("sof_cycle", sof_at, 1);
      check("frame_strobes", n, v.pm);
      check("gnt_held", int'(gnt_bad), 0);
      if (v.done_at > 0) check("done_cycle", fin_at, v.done_at);
      else check("done_seen", int'(fin_at > 0), 1);
    end
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, nsof, ndone, sof2, done1, sof_at, err_at, fin_at;

    vecs[0] = '{0,   5,   3, 0, 1'b0,   7};
    vecs[1] = '{1,   1,   0, 0, 1'b0,   3};
    vecs[2] = '{2,   4,   4, 0, 1'b0,   6};
    vecs[3] = '{3,   8,   2, 1, 1'b0,  17};
    vecs[4] = '{1,   0,   0, 0, 1'b1,   0};
    vecs[5] = '{2,   4,   6, 0, 1'b1,   0};
    vecs[6] = '{3, 255, 255, 0, 1'b0, 257};
    vecs[7] = '{0,   6,   1, 2, 1'b0,   0};

    req = '0; ch_pm = '0; ch_cm = '0; ready_in = 1'b0; rst_n = 1'b0;
    do_reset("reset_outputs");

    // All four channels requesting: grants 0,1,2,3,0 with a one-cycle gap.
    for (int i = 0; i < 4; i++) set_cfg(i, i + 2, 1);
    for (int i = 0; i < 4; i++) push_exp(i, i + 2, 1, 1'b0);
    push_exp(0, 2, 1, 1'b0);
    @(posedge clk);
    #1;
    req = 4'hF; ready_in = 1'b1;
    cyc = 0; nsof = 0; ndone = 0; sof2 = -1; done1 = -1;
    while (ndone < 5 && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
      if (sof_out) begin
        nsof++;
        if (nsof == 2) sof2 = cyc;
        if (nsof == 5) req = '0;
      end
      if (frame_done) begin
        ndone++;
        if (ndone == 1) done1 = cyc;
      end
    end
    req = '0; ready_in = 1'b0;
    check("rr_frames", ndone, 5);
    check("rr_sofs", nsof, 5);
    check("b2b_gap", sof2 - done1, 1);
    check("rr_sb_drained", int'(sb_q.size()), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // ch2 invalid, ch3 valid, both requesting from rr_ptr 0.
    do_reset("reset_outputs_2");
    set_cfg(2, 4, 6);
    set_cfg(3, 3, 1);
    push_exp(2, 4, 6, 1'b1);
    push_exp(3, 3, 1, 1'b0);
    @(posedge clk);
    #1;
    req = 4'b1100; ready_in = 1'b1;
    cyc = 0; sof_at = -1; err_at = -1; fin_at = -1;
    while (fin_at < 0 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
      if (cfg_err && err_at < 0) err_at = cyc;
      if (sof_out && sof_at < 0) begin sof_at = cyc; req = '0; end
      if (frame_done) fin_at = cyc;
    end
    req = '0; ready_in = 1'b0;
    check("cfg_err_cycle", err_at, 1);
    check("ch3_sof_cycle", sof_at, 2);
    check("ch3_done_cycle", fin_at, 6);

    // Reset asserted mid-RUN, then a fresh frame.
    set_cfg(0, 10, 2);
    push_exp(0, 10, 2, 1'b0);
    @(posedge clk);
    #1;
    req = 4'b0001; ready_in = 1'b1;
    cyc = 0;
    while (cyc < 4) begin
      @(posedge clk);
      #2;
      cyc++;
      if (sof_out) req = '0;
    end
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_valid", int'(valid_out), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec('{1, 3, 0, 0, 1'b0, 5});

`ifdef STUFF_SCHED_TIMEOUT_EN
    // Two slots then a permanent stall on ch1; ch2 must be served after the abort.
    do_reset("reset_outputs_3");
    set_cfg(1, 6, 0);
    set_cfg(2, 2, 1);
    push_exp(1, 6, 0, 1'b0);
    push_exp(2, 2, 1, 1'b0);
    @(posedge clk);
    #1;
    req = 4'b0110;
    cyc = 0; sof_at = -1; err_at = -1; fin_at = -1; nsof = 0;
    while (fin_at < 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      ready_in = (cyc <= 3) || (err_at >= 0);
      #1;
      if (sof_out) begin
        nsof++;
        if (nsof == 1) req[1] = 1'b0;
        if (nsof == 2) begin sof_at = cyc; req = '0; end
      end
      if (frame_abort && err_at < 0) begin
        err_at = cyc;
        check("abort_busy_clear", int'(busy), 0);
      end
      if (frame_done) fin_at = cyc;
    end
    req = '0; ready_in = 1'b0;
    check("abort_cycle", err_at, 20);
    check("next_sof_cycle", sof_at, 21);
    check("next_done_seen", int'(fin_at > 0), 1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
